riscv_writeback: RTL and testbench

- Write side of the register file. Tracks every issued destination register through a fixed-depth pipeline.
- Selects the writeback source and aligns/extends load data.
- Drives AddrD/DataD/RegWEn into riscv_regfile and publishes a pending-write scoreboard mask used by issue/hazard logic.
- Sits between the execute/memory stages and riscv_regfile.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/riscv_load_align.sv | 42 ++++
 rtl/riscv_writeback.sv | 116 +++++++++++
 tb/tb_riscv_writeback.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the register-file write side: writeback source select,
// load funct3 encodings and the in-flight pipeline entry.
package riscv_pkg;

    localparam int RF_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rd;
        wb_sel_e              sel;
        logic [2:0]           funct3;
        logic [1:0]           off;
    } wb_entry_t;

endpackage

// File: rtl/riscv_load_align.sv
// Load data alignment: picks byte/halfword/word at the byte offset and
// sign/zero-extends it; flags misaligned offsets and illegal funct3.
module riscv_load_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] data_o,
    output logic            err_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = '0;
        err_o  = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH: begin
                data_o = {{(XLEN-16){half_v[15]}}, half_v};
                err_o  = off_i[0];
            end
            F3_LHU: begin
                data_o = {{(XLEN-16){1'b0}}, half_v};
                err_o  = off_i[0];
            end
            F3_LW: begin
                data_o = word_i;
                err_o  = (off_i != 2'b00);
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_writeback.sv
// Register-file write side: tracks issued destinations through a fixed-depth
// pipeline, commits the head to AddrD/DataD/RegWEn and publishes a busy mask.
module riscv_writeback
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PIPE_DEPTH = 3,
    parameter int RADDR_W    = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               issue_valid_i,
    input  logic [RADDR_W-1:0] issue_rd_i,
    input  logic [1:0]         issue_wb_sel_i,
    input  logic [2:0]         issue_funct3_i,
    input  logic [1:0]         issue_off_i,
    input  logic [XLEN-1:0]    alu_result_i,
    input  logic [XLEN-1:0]    mem_rdata_i,
    input  logic [XLEN-1:0]    pc_plus4_i,
    output logic [RADDR_W-1:0] AddrD_o,
    output logic [XLEN-1:0]    DataD_o,
    output logic               RegWEn_o,
    output logic [31:0]        busy_o,
    output logic               err_o
);

    localparam int NSTG = PIPE_DEPTH - 1;
    localparam int HEAD = PIPE_DEPTH - 2;

    wb_entry_t          stage_q [NSTG];
    wb_entry_t          issue_e;
    wb_entry_t          head;
    logic [RADDR_W-1:0] addr_q;
    logic [XLEN-1:0]    data_q, data_d;
    logic               wen_q, wen_d;
    logic               err_q, err_d;
    logic [XLEN-1:0]    load_data;
    logic               load_err;
    logic [31:0]        busy_mask;

    assign head = stage_q[HEAD];

    always_comb begin
        issue_e.valid  = issue_valid_i;
        issue_e.rd     = issue_rd_i;
        issue_e.sel    = wb_sel_e'(issue_wb_sel_i);
        issue_e.funct3 = issue_funct3_i;
        issue_e.off    = issue_off_i;
    end

    riscv_load_align #(.XLEN(XLEN)) u_align (
        .funct3_i (head.funct3),
        .off_i    (head.off),
        .word_i   (mem_rdata_i),
        .data_o   (load_data),
        .err_o    (load_err)
    );

    always_comb begin
        case (head.sel)
            WB_ALU:  data_d = alu_result_i;
            WB_MEM:  data_d = load_data;
            WB_PC4:  data_d = pc_plus4_i;
            default: data_d = '0;
        endcase
        err_d = head.valid && (head.sel == WB_MEM) && load_err;
        wen_d = head.valid && (head.rd != '0) && (head.sel != WB_NONE) &&
                !((head.sel == WB_MEM) && load_err);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NSTG; i++) stage_q[i] <= '0;
            addr_q <= '0;
            data_q <= '0;
            wen_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (stall_i) begin
            // Head is held so it can still commit once the stall lifts.
            wen_q <= 1'b0;
            err_q <= 1'b0;
            if (flush_i) begin
                for (int i = 0; i < HEAD; i++) stage_q[i].valid <= 1'b0;
            end
        end else begin
            addr_q     <= head.rd;
            data_q     <= data_d;
            wen_q      <= wen_d;
            err_q      <= err_d;
            stage_q[0] <= issue_e;
            if (flush_i) stage_q[0].valid <= 1'b0;
            for (int i = 1; i <= HEAD; i++) begin
                stage_q[i] <= stage_q[i-1];
                if (flush_i) stage_q[i].valid <= 1'b0;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NSTG; i++) begin
            if (stage_q[i].valid && (stage_q[i].sel != WB_NONE)) busy_mask[stage_q[i].rd] = 1'b1;
        end
        if (wen_q) busy_mask[addr_q] = 1'b1;
        busy_mask[0] = 1'b0;
    end

    assign AddrD_o  = addr_q;
    assign DataD_o  = data_q;
    assign RegWEn_o = wen_q;
    assign err_o    = err_q;
    assign busy_o   = busy_mask;

endmodule

// File: tb/tb_riscv_writeback.sv
// Directed and randomized checks of riscv_writeback against a queue-based
// model of in-flight writes with per-item remaining-advance counts.
module tb_riscv_writeback;

    localparam int PD = 3;

    logic        clk = 1'b0;
    logic        rst_i, stall_i, flush_i, issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic [1:0]  issue_wb_sel_i;
    logic [2:0]  issue_funct3_i;
    logic [1:0]  issue_off_i;
    logic [31:0] alu_result_i, mem_rdata_i, pc_plus4_i;
    logic [4:0]  AddrD_o;
    logic [31:0] DataD_o;
    logic        RegWEn_o;
    logic [31:0] busy_o;
    logic        err_o;

    riscv_writeback #(.XLEN(32), .PIPE_DEPTH(PD), .RADDR_W(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .issue_wb_sel_i(issue_wb_sel_i), .issue_funct3_i(issue_funct3_i),
        .issue_off_i(issue_off_i), .alu_result_i(alu_result_i),
        .mem_rdata_i(mem_rdata_i), .pc_plus4_i(pc_plus4_i),
        .AddrD_o(AddrD_o), .DataD_o(DataD_o), .RegWEn_o(RegWEn_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rd;
        logic [1:0] sel;
        logic [2:0] f3;
        logic [1:0] off;
        int         rem;
    } item_t;

    item_t       q[$];
    logic        e_wen, e_err;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic ld_bad(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return off[0];
            3'd2:       return off != 2'd0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (8 * off)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] m = '0;
        foreach (q[i]) if (q[i].sel != 2'd3) m[q[i].rd] = 1'b1;
        if (e_wen) m[e_addr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // One clock: advance the model with the inputs present at the edge, then check.
    task automatic tick();
        item_t it, kept[$];
        logic  bad;
        @(posedge clk);
        if (rst_i) begin
            q.delete();
            e_wen = 0; e_err = 0; e_addr = 0; e_data = 0;
        end else if (stall_i) begin
            e_wen = 0; e_err = 0;
            if (flush_i) begin
                foreach (q[i]) if (q[i].rem == 0) kept.push_back(q[i]);
                q = kept;
            end
        end else begin
            e_wen = 0; e_err = 0;
            if (q.size() > 0 && q[0].rem == 0) begin
                it = q.pop_front();
                bad = (it.sel == 2'd1) && ld_bad(it.f3, it.off);
                e_addr = it.rd;
                case (it.sel)
                    2'd0:    e_data = alu_result_i;
                    2'd1:    e_data = ld_val(it.f3, it.off, mem_rdata_i);
                    default: e_data = pc_plus4_i;
                endcase
                e_err = bad;
                e_wen = (it.rd != 0) && (it.sel != 2'd3) && !bad;
            end
            foreach (q[i]) q[i].rem--;
            if (flush_i) q.delete();
            else if (issue_valid_i)
                q.push_back('{rd: issue_rd_i, sel: issue_wb_sel_i, f3: issue_funct3_i,
                              off: issue_off_i, rem: PD - 2});
        end
        #1;
        chk("RegWEn", {31'd0, RegWEn_o}, {31'd0, e_wen});
        chk("err", {31'd0, err_o}, {31'd0, e_err});
        chk("busy", busy_o, model_busy());
        if (e_wen) begin
            chk("AddrD", {27'd0, AddrD_o}, {27'd0, e_addr});
            chk("DataD", DataD_o, e_data);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [1:0] off);
        issue_valid_i = iv; issue_rd_i = rd; issue_wb_sel_i = sel;
        issue_funct3_i = f3; issue_off_i = off;
    endtask

    logic [31:0] exp_ld [5];
    logic [2:0]  ld_f3  [5];
    logic [1:0]  ld_off [5];

    initial begin
        rst_i = 1; stall_i = 0; flush_i = 0;
        drive(0, 0, 0, 0, 0);
        alu_result_i = 0; mem_rdata_i = 0; pc_plus4_i = 0;
        e_wen = 0; e_err = 0; e_addr = 0; e_data = 0;

        // Reset state
        tick(); tick();
        chk("rst_AddrD", {27'd0, AddrD_o}, 32'd0);
        chk("rst_DataD", DataD_o, 32'd0);
        chk("rst_busy", busy_o, 32'd0);
        rst_i = 0;

        // ALU write to x5 with latency PD
        drive(1, 5, 2'd0, 0, 0); tick();
        chk("alu_busy5_issue", {31'd0, busy_o[5]}, 32'd1);
        drive(0, 0, 0, 0, 0); tick();
        alu_result_i = 32'hDEADBEEF; tick();
        chk("alu_wen", {31'd0, RegWEn_o}, 32'd1);
        chk("alu_addr", {27'd0, AddrD_o}, 32'd5);
        chk("alu_data", DataD_o, 32'hDEADBEEF);
        chk("alu_busy5_wr", {31'd0, busy_o[5]}, 32'd1);
        tick();
        chk("alu_busy5_after", {31'd0, busy_o[5]}, 32'd0);

        // Loads back to back
        mem_rdata_i = 32'h8081_7F80;
        ld_f3  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        ld_off = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
        exp_ld = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_8081, 32'h0000_8081, 32'h8081_7F80};
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(1, 5'(8 + i), 2'd1, ld_f3[i], ld_off[i]);
            else drive(0, 0, 0, 0, 0);
            tick();
            if (i >= 2) chk("load_data", DataD_o, exp_ld[i-2]);
        end

        // Misaligned LW and illegal funct3
        drive(1, 13, 2'd1, 3'd2, 2'd1); tick();
        drive(1, 14, 2'd1, 3'd3, 2'd0); tick();
        drive(0, 0, 0, 0, 0); tick();
        chk("lw_mis_err", {31'd0, err_o}, 32'd1);
        chk("lw_mis_wen", {31'd0, RegWEn_o}, 32'd0);
        chk("lw_mis_busy13", {31'd0, busy_o[13]}, 32'd0);
        tick();
        chk("f3_ill_err", {31'd0, err_o}, 32'd1);
        chk("f3_ill_busy14", {31'd0, busy_o[14]}, 32'd0);
        tick();

        // x0 is never written nor busy
        drive(1, 0, 2'd0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); tick(); tick();
        chk("x0_wen", {31'd0, RegWEn_o}, 32'd0);
        chk("x0_busy", {31'd0, busy_o[0]}, 32'd0);

        // Stall mid-stream keeps order
        pc_plus4_i = 32'h0000_1004;
        drive(1, 1, 2'd2, 0, 0); tick();
        drive(1, 2, 2'd2, 0, 0); tick();
        drive(1, 3, 2'd2, 0, 0); tick();
        chk("stl_w1", {27'd0, AddrD_o}, 32'd1);
        drive(1, 9, 2'd0, 0, 0); stall_i = 1; tick();
        chk("stl_nowen_a", {31'd0, RegWEn_o}, 32'd0);
        tick();
        chk("stl_nowen_b", {31'd0, RegWEn_o}, 32'd0);
        drive(0, 0, 0, 0, 0); stall_i = 0; tick();
        chk("stl_w2", {27'd0, AddrD_o}, 32'd2);
        tick();
        chk("stl_w3", {27'd0, AddrD_o}, 32'd3);
        tick();

        // Flush with x4 at head
        drive(1, 4, 2'd0, 0, 0); tick();
        drive(1, 6, 2'd0, 0, 0); tick();
        drive(1, 7, 2'd0, 0, 0); flush_i = 1; tick();
        chk("fl_w4", {27'd0, AddrD_o}, 32'd4);
        chk("fl_busy6", {31'd0, busy_o[6]}, 32'd0);
        chk("fl_busy7", {31'd0, busy_o[7]}, 32'd0);
        drive(0, 0, 0, 0, 0); flush_i = 0; tick();
        chk("fl_nowen", {31'd0, RegWEn_o}, 32'd0);
        tick();

        // Flush and stall together: head survives
        drive(1, 24, 2'd0, 0, 0); tick();
        drive(1, 25, 2'd0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); stall_i = 1; flush_i = 1; tick();
        chk("fs_busy25", {31'd0, busy_o[25]}, 32'd0);
        chk("fs_busy24", {31'd0, busy_o[24]}, 32'd1);
        stall_i = 0; flush_i = 0; tick();
        chk("fs_w24", {27'd0, AddrD_o}, 32'd24);
        tick();

        // Reset with entries in flight
        drive(1, 20, 2'd0, 0, 0); tick();
        drive(1, 21, 2'd0, 0, 0); tick();
        drive(1, 22, 2'd0, 0, 0); rst_i = 1; tick();
        chk("mrst_addr", {27'd0, AddrD_o}, 32'd0);
        chk("mrst_data", DataD_o, 32'd0);
        chk("mrst_busy", busy_o, 32'd0);
        drive(0, 0, 0, 0, 0); rst_i = 0; tick(); tick(); tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 2'($urandom),
                  3'($urandom), 2'($urandom));
            stall_i      = ($urandom_range(0, 4) == 0);
            flush_i      = ($urandom_range(0, 9) == 0);
            rst_i        = ($urandom_range(0, 49) == 0);
            alu_result_i = $urandom;
            mem_rdata_i  = $urandom;
            pc_plus4_i   = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
